// File: rtl/pll_reset_sequencer.sv
// Sequences system reset around ECP5 PLL lock: pulses PLL RST, qualifies synchronized LOCK, then releases sys_rst_n.
// Optional lock watchdog compiled in with `define PLLSEQ_WATCHDOG_EN.
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES        = 16,
   parameter int PLL_RST_CYCLES     = 8,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int RETRY_W            = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pll_lock,
   output logic               pll_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_count
);

   localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int PW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;

   if (LOCK_STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || PLL_RST_CYCLES < 1 ||
       LOCK_TIMEOUT < 1 || RETRY_W < 1) begin : g_param_chk
      $error("pll_reset_sequencer: all limits must be >= 1");
   end

   typedef enum logic [2:0] {
      S_PLLRST, S_WAIT, S_STABLE, S_HOLD, S_RUN
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [SW-1:0]   stab_q, stab_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [PW-1:0]   prst_q, prst_d;
   logic            pll_rst_q, pll_rst_d;
   logic            sys_rst_n_q, sys_rst_n_d;
   logic            lock_lost_q, lock_lost_d;
   logic            lock_s;

`ifdef PLLSEQ_WATCHDOG_EN
   localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   assign lock_s = sync_q[1];

   always_comb begin
      sync_d      = {sync_q[0], pll_lock};
      state_d     = state_q;
      stab_d      = stab_q;
      hold_d      = hold_q;
      prst_d      = prst_q;
      lock_lost_d = 1'b0;
      case (state_q)
         S_PLLRST: begin
            if (prst_q == PW'(PLL_RST_CYCLES - 1)) begin
               state_d = S_WAIT;
               prst_d  = '0;
            end else begin
               prst_d = prst_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (lock_s) begin
               state_d = S_STABLE;
               stab_d  = '0;
            end
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_d = S_WAIT;
               stab_d  = '0;
            end else if (stab_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = S_HOLD;
               stab_d  = '0;
               hold_d  = '0;
            end else begin
               stab_d = stab_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (!lock_s) begin
               state_d = S_WAIT;
               hold_d  = '0;
            end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = S_RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_d     = S_WAIT;
               lock_lost_d = 1'b1;
            end
         end
         default: state_d = S_PLLRST;
      endcase

`ifdef PLLSEQ_WATCHDOG_EN
      // Expiry overrides whatever the lock path decided this cycle.
      retry_d = retry_q;
      tmo_d   = '0;
      if (state_q == S_WAIT || state_q == S_STABLE) begin
         if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_d = S_PLLRST;
            prst_d  = '0;
            stab_d  = '0;
            retry_d = (&retry_q) ? retry_q : retry_q + 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif

      pll_rst_d   = (state_d == S_PLLRST);
      sys_rst_n_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PLLRST;
         sync_q      <= '0;
         stab_q      <= '0;
         hold_q      <= '0;
         prst_q      <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         stab_q      <= stab_d;
         hold_q      <= hold_d;
         prst_q      <= prst_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         lock_lost_q <= lock_lost_d;
      end
   end

`ifdef PLLSEQ_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q   <= '0;
         retry_q <= '0;
      end else begin
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
      end
   end
   assign retry_count = retry_q;
`else
   assign retry_count = '0;
`endif

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = sys_rst_n_q;
   assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: behavioural lock-qualification model checked every cycle plus literal timing pins.
module tb_pll_reset_sequencer;

   localparam int L = 8, H = 4, P = 3, T = 32, RW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          pll_lock = 1'b0;
   logic          pll_rst, sys_rst_n, ready, lock_lost;
   logic [RW-1:0] retry_count;

   int checks = 0;
   int errors = 0;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(L), .HOLD_CYCLES(H), .PLL_RST_CYCLES(P),
      .LOCK_TIMEOUT(T), .RETRY_W(RW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst(pll_rst),
      .sys_rst_n(sys_rst_n), .ready(ready), .lock_lost(lock_lost),
      .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

`ifdef PLLSEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   // Model: lock_s is pll_lock two edges late; after the PLL pulse, sys reset releases
   // once lock_s has been seen high on L+H+1 consecutive edges.
   int m_s1, m_s2, prst_left, running, run_len, wait_edges, m_retry, m_lost;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; prst_left = P; running = 0; run_len = 0;
      wait_edges = 0; m_retry = 0; m_lost = 0;
   endtask

   task automatic model_step(input int lock_in);
      int ls;
      bit in_ws;
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = lock_in;
      m_lost = 0;
      if (prst_left > 0) begin
         prst_left--;
         run_len = 0;
         wait_edges = 0;
      end else if (running != 0) begin
         wait_edges = 0;
         if (ls == 0) begin
            running = 0;
            m_lost = 1;
            run_len = 0;
         end
      end else begin
         in_ws = (run_len <= L);
         if (WD && in_ws && wait_edges + 1 == T) begin
            prst_left = P;
            run_len = 0;
            wait_edges = 0;
            if (m_retry < (1 << RW) - 1) m_retry++;
         end else begin
            wait_edges = in_ws ? wait_edges + 1 : 0;
            if (ls != 0) begin
               run_len++;
               if (run_len == L + H + 1) running = 1;
            end else begin
               run_len = 0;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst_n) model_reset();
      else model_step(int'(pll_lock));
      chk("m_pll_rst", int'(pll_rst), (prst_left > 0) ? 1 : 0);
      chk("m_sys_rst_n", int'(sys_rst_n), running);
      chk("m_ready", int'(ready), running);
      chk("m_lock_lost", int'(lock_lost), m_lost);
      chk("m_retry", int'(retry_count), m_retry);
   end

   task automatic edge1();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, int'(pll_rst), 1);
      chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
      chk({tag, "_ready"}, int'(ready), 0);
      chk({tag, "_lock_lost"}, int'(lock_lost), 0);
      chk({tag, "_retry"}, int'(retry_count), 0);
   endtask

   // pll_lock sampled first at the next edge; sys reset must rise on the 15th edge counting that one
   task automatic check_release(input string tag, input int edge_no);
      for (int i = 1; i < edge_no; i++) edge1();
      chk({tag, "_pre"}, int'(sys_rst_n), 0);
      edge1();
      chk({tag, "_rise"}, int'(sys_rst_n), 1);
      chk({tag, "_ready"}, int'(ready), 1);
   endtask

   initial begin
      int lost_seen, prst_seen, prst_rises;
      logic prev;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("por");
      repeat (2) @(negedge clk);

      // Power-up
      rst_n = 1'b1;
      edge1(); chk("pu_prst_e1", int'(pll_rst), 1);
      edge1(); chk("pu_prst_e2", int'(pll_rst), 1);
      edge1(); chk("pu_prst_e3", int'(pll_rst), 0);
      repeat (8) @(negedge clk);
      pll_lock = 1'b1;
      check_release("pu", L + H + 3);

      // Run-time loss
      @(negedge clk); pll_lock = 1'b0;
      edge1(); chk("loss_e1_sys", int'(sys_rst_n), 1);
      edge1(); chk("loss_e2_sys", int'(sys_rst_n), 1);
      chk("loss_e2_lost", int'(lock_lost), 0);
      edge1(); chk("loss_e3_sys", int'(sys_rst_n), 0);
      chk("loss_e3_lost", int'(lock_lost), 1);
      prst_seen = 0;
      edge1(); chk("loss_e4_lost", int'(lock_lost), 0);
      for (int i = 0; i < 16; i++) begin
         edge1();
         if (pll_rst) prst_seen++;
      end
      chk("loss_no_pll_rst", prst_seen, 0);
      @(negedge clk); pll_lock = 1'b1;
      check_release("restore", L + H + 3);

      // Bounce during STABLE
      @(negedge clk); pll_lock = 1'b0;
      repeat (6) @(negedge clk);
      lost_seen = 0;
      pll_lock = 1'b1;
      for (int i = 0; i < 5; i++) begin @(negedge clk); lost_seen += int'(lock_lost); end
      pll_lock = 1'b0;
      for (int i = 0; i < 2; i++) begin @(negedge clk); lost_seen += int'(lock_lost); end
      pll_lock = 1'b1;
      for (int i = 1; i < L + H + 3; i++) begin edge1(); lost_seen += int'(lock_lost); end
      chk("bounce_pre", int'(sys_rst_n), 0);
      edge1();
      chk("bounce_rise", int'(sys_rst_n), 1);
      chk("bounce_no_lost", lost_seen, 0);

      // Reset mid-HOLD
      @(negedge clk); pll_lock = 1'b0;
      repeat (4) @(negedge clk);
      pll_lock = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("hold_sys_low", int'(sys_rst_n), 0);
      rst_n = 1'b0;
      #1 chk_reset_vals("midhold");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      edge1(); chk("rr_prst_e1", int'(pll_rst), 1);
      edge1(); chk("rr_prst_e2", int'(pll_rst), 1);
      edge1(); chk("rr_prst_e3", int'(pll_rst), 0);
      // sync restarts from 0 while in PLLRST, so lock qualifies from edge 4
      for (int i = 4; i < L + H + 4; i++) edge1();
      chk("rr_pre", int'(sys_rst_n), 0);
      edge1();
      chk("rr_rise", int'(sys_rst_n), 1);

      // Lock never arrives
      @(negedge clk); pll_lock = 1'b0;
      repeat (8) @(negedge clk);
      prst_rises = 0;
      prev = pll_rst;
      for (int i = 0; i < 20 * (T + P); i++) begin
         edge1();
         if (pll_rst && !prev) prst_rises++;
         prev = pll_rst;
      end
      if (WD) begin
         chk("wd_pulses", prst_rises, 20);
         chk("wd_retry_sat", int'(retry_count), 15);
      end else begin
         chk("nowd_pulses", prst_rises, 0);
         chk("nowd_retry", int'(retry_count), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the system reset around the ECP5 PLL (EHXPLLL) lock. It runs on the raw oscillator clock and drives the PLL `RST` input. It synchronizes and qualifies `LOCK`, then releases a clean active-low reset to the rest of the LED display fabric only after lock has been stable. Loss of lock at run time re-asserts system reset. An optional watchdog re-pulses the PLL when lock never arrives.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before entering hold.
- `HOLD_CYCLES`, 16: extra cycles `sys_rst_n` stays low after lock qualifies.
- `PLL_RST_CYCLES`, 8: width of each `pll_rst` pulse.
- `LOCK_TIMEOUT`, 65536: watchdog limit in WAIT_LOCK+STABLE, in cycles. Only used with the watchdog compiled in.
- `RETRY_W`, 4: width of the retry counter.
- `clk` input 1: oscillator clock. Free-running and independent of the PLL output.
- `rst_n` input 1: asynchronous active-low reset.
- `pll_lock` input 1: EHXPLLL `LOCK`. Asynchronous to `clk`.
- `pll_rst` output 1: to EHXPLLL `RST`, active high.
- `sys_rst_n` output 1: active-low reset for the downstream design. Registered.
- `ready` output 1: high exactly when `sys_rst_n` is high.
- `lock_lost` output 1: one-cycle pulse when lock drops while in RUN.
- `retry_count` output `RETRY_W`: number of watchdog PLL resets. Saturating.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. All decisions use `lock_s` only.
- PLLRST state: `pll_rst`=1 for `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK. The timeout counter is cleared on exit.
- WAIT_LOCK state:
  - `lock_s`=1 → go to STABLE with the stable counter at 0.
- STABLE state:
  - Counts cycles with `lock_s`=1.
  - `lock_s`=0 → back to WAIT_LOCK, and the stable counter clears.
  - Count reaches `LOCK_STABLE_CYCLES` → go to HOLD.
- HOLD state:
  - Counts `HOLD_CYCLES`, then go to RUN.
  - `lock_s`=0 during HOLD → WAIT_LOCK.
- RUN state: `sys_rst_n`=1 and `ready`=1.
  - `lock_s`=0 → `lock_lost` pulses for one cycle.
  - `sys_rst_n` and `ready` go low on the same edge, and the state goes to WAIT_LOCK.
  - No PLL reset is issued on loss of lock.
- `sys_rst_n` is 0 in every state except RUN.
- Counters are sized with `$clog2` of their limit and never wrap. Each holds at its terminal value until the state changes.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = PLLRST
  - `pll_rst`=1
  - `sys_rst_n`=0
  - `ready`=0
  - `lock_lost`=0
  - `retry_count`=0
  - all counters 0
  - both synchronizer flops 0
- After `rst_n` rises, `pll_rst` stays high for exactly `PLL_RST_CYCLES` rising edges.
- Lock latency: `pll_lock` is held high from the first edge that samples it, with no drop. `sys_rst_n` and `ready` then rise exactly `LOCK_STABLE_CYCLES + HOLD_CYCLES + 3` edges later.
- Lock loss: `pll_lock` falls while in RUN. `lock_lost`=1 and `sys_rst_n`=0 appear 3 edges after the first edge that samples it low (2 synchronizer edges plus 1 registered edge).
- Glitch handling: a glitch shorter than one cycle may be missed. Any single-cycle low on `lock_s` during STABLE restarts qualification.
- `rst_n` asserted mid-operation: every output returns immediately (asynchronously) to its reset value, including `retry_count`.
- Simultaneous events: a watchdog expiry and `lock_s` rising on the same cycle resolve in favour of the watchdog (PLLRST).

## Configuration
- Macro: `PLLSEQ_WATCHDOG_EN`.
- When defined:
  - A timeout counter runs in WAIT_LOCK and STABLE, and is not cleared by a STABLE→WAIT_LOCK bounce.
  - On reaching `LOCK_TIMEOUT`: go to PLLRST, and `retry_count` increments, saturating at all-ones.
- When undefined:
  - No timeout counter. WAIT_LOCK waits forever.
  - `retry_count` is tied to 0.
  - PLLRST is entered only after `rst_n`.

## Test plan
All scenarios use `LOCK_STABLE_CYCLES`=8, `HOLD_CYCLES`=4, `PLL_RST_CYCLES`=3, `LOCK_TIMEOUT`=32.
- Power-up. Stimulus: release `rst_n`, assert `pll_lock` 10 cycles later. Required response:
  - `pll_rst` is high for 3 edges after release.
  - `sys_rst_n` and `ready` rise 15 edges after `pll_lock` is first sampled high.
- Bounce. Stimulus: `pll_lock` high for 5 cycles, low for 2, then high. Required response:
  - Qualification restarts.
  - `sys_rst_n` rises 15 edges after the second rise.
  - `lock_lost` stays 0.
- Run-time loss. Stimulus: in RUN, drop `pll_lock` for 20 cycles, then restore. Required response:
  - `lock_lost` is a single-cycle pulse.
  - `sys_rst_n` is low 3 edges after the drop.
  - `pll_rst` stays 0.
  - `sys_rst_n` rises again 15 edges after the restore.
- Watchdog (`PLLSEQ_WATCHDOG_EN`). Stimulus: `pll_lock` held at 0. Required response:
  - `pll_rst` pulses for 3 cycles every 35 cycles.
  - `retry_count` counts 1, 2, … and saturates at 15.
- No watchdog (macro undefined), same stimulus as the watchdog test. Required response: after the initial pulse, `pll_rst`=0 forever and `retry_count`=0.
- Reset mid-HOLD. Stimulus: assert `rst_n`=0 during HOLD. Required response:
  - All outputs take their reset values asynchronously.
  - After release, the full sequence repeats from PLLRST.
